// File: rtl/rgb_fader.sv
// Three-channel LED fader: each channel ramps its PWM level up or down one
// step per prescaler strobe, following a registered copy of the colour targets.
module rgb_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_data,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b,
  output logic       o_busy
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } ch_state_t;

  // channel index i follows i_data[i]: 0 = blue, 1 = green, 2 = red
  logic [2:0]          target;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                step;

  ch_state_t           state_q [3];
  ch_state_t           state_d [3];
  logic [PWM_BITS-1:0] level_q [3];
  logic [PWM_BITS-1:0] level_d [3];
  logic [2:0]          led_d;
  logic                busy_d;

  assign step = (pre_cnt == PRE_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      target  <= '0;
      pwm_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      target  <= i_data;
      pwm_cnt <= pwm_cnt + 1'b1;
      pre_cnt <= step ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= OFF;
        level_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
      end
    end
  end

  // A target flip wins over reaching an end point; the step still applies
  // on the edge the direction reverses.
  always_comb begin
    busy_d = 1'b0;
    led_d  = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
      case (state_q[i])
        OFF: begin
          level_d[i] = '0;
          if (target[i]) state_d[i] = RISE;
        end
        RISE: begin
          if (step && (level_q[i] != MAX)) level_d[i] = level_q[i] + 1'b1;
          if (!target[i])              state_d[i] = FALL;
          else if (level_d[i] == MAX)  state_d[i] = ON;
        end
        ON: begin
          level_d[i] = MAX;
          if (!target[i]) state_d[i] = FALL;
        end
        FALL: begin
          if (step && (level_q[i] != '0)) level_d[i] = level_q[i] - 1'b1;
          if (target[i])              state_d[i] = RISE;
          else if (level_d[i] == '0)  state_d[i] = OFF;
        end
        default: begin
          state_d[i] = OFF;
          level_d[i] = '0;
        end
      endcase
      led_d[i] = (level_q[i] == MAX) || (level_q[i] > pwm_cnt);
      if ((state_q[i] == RISE) || (state_q[i] == FALL)) busy_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_led_r <= 1'b0;
      o_led_g <= 1'b0;
      o_led_b <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_led_r <= led_d[2];
      o_led_g <= led_d[1];
      o_led_b <= led_d[0];
      o_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_rgb_fader.sv
// Bench for rgb_fader: table vectors, directed corner sequences and random
// target changes checked every cycle against a direction/moving model.
module tb_rgb_fader;

  localparam int STEP = 2;
  localparam int LMAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] data = 3'b000;
  logic       led_r, led_g, led_b, busy;

  logic       rst_s = 1'b1;
  logic [2:0] data_s = 3'b000;
  logic       led_r_s, led_g_s, led_b_s, busy_s;

  always #5 clk = ~clk;

  rgb_fader #(.PWM_BITS(3), .STEP_DIV(STEP)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data),
    .o_led_r(led_r), .o_led_g(led_g), .o_led_b(led_b), .o_busy(busy)
  );

  // slow stepping so a mid level persists across several PWM periods
  rgb_fader #(.PWM_BITS(3), .STEP_DIV(32)) dut_slow (
    .i_clk(clk), .i_rst(rst_s), .i_data(data_s),
    .o_led_r(led_r_s), .o_led_g(led_g_s), .o_led_b(led_b_s), .o_busy(busy_s)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel has a direction (last target acted on) and a
  // moving flag; levels move one step per strobe while moving.
  int m_t [3], m_l [3], m_up [3], m_mv [3], m_led [3];
  int m_p, m_pre, m_busy;
  bit m_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_t[i] = 0; m_l[i] = 0; m_up[i] = 0; m_mv[i] = 0; m_led[i] = 0;
      end
      m_p = 0; m_pre = 0; m_busy = 0;
    end else begin
      m_s = (m_pre == STEP - 1);
      m_busy = 0;
      for (int i = 0; i < 3; i++) begin
        m_led[i] = ((m_l[i] == LMAX) || (m_l[i] > m_p)) ? 1 : 0;
        if (m_mv[i] != 0) m_busy = 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (m_s && m_mv[i] != 0) begin
          if (m_up[i] != 0) m_l[i] = (m_l[i] < LMAX) ? m_l[i] + 1 : LMAX;
          else              m_l[i] = (m_l[i] > 0) ? m_l[i] - 1 : 0;
        end
        if (m_t[i] != m_up[i]) begin
          m_up[i] = m_t[i];
          m_mv[i] = 1;
        end else if (m_mv[i] != 0 && ((m_up[i] != 0 && m_l[i] == LMAX) || (m_up[i] == 0 && m_l[i] == 0))) begin
          m_mv[i] = 0;
        end
      end
      for (int i = 0; i < 3; i++) m_t[i] = int'(data[i]);
      m_p   = (m_p + 1) % (LMAX + 1);
      m_pre = (m_pre + 1) % STEP;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_led_r", int'(led_r), m_led[2]);
      check("model_led_g", int'(led_g), m_led[1]);
      check("model_led_b", int'(led_b), m_led[0]);
      check("model_busy",  int'(busy),  m_busy);
    end
  end

  typedef struct {
    logic [2:0] data;
    int         cycles;
    logic [3:0] exp;   // {r, g, b, busy}
  } vec_t;

  vec_t vecs [12];

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   cnt_rise [3];
    int   cnt_fall [3];
    int   seq [$];
    int   last, lv, waited;
    logic [3:0] outs;

    vecs[0]  = '{3'b100,  2, 4'b0000};
    vecs[1]  = '{3'b100,  1, 4'b0001};
    vecs[2]  = '{3'b100, 20, 4'b1000};
    vecs[3]  = '{3'b110,  3, 4'b1001};
    vecs[4]  = '{3'b110, 30, 4'b1100};
    vecs[5]  = '{3'b011, 40, 4'b0110};
    vecs[6]  = '{3'b000, 40, 4'b0000};
    vecs[7]  = '{3'b111, 40, 4'b1110};
    vecs[8]  = '{3'b101,  3, 4'b1111};
    vecs[9]  = '{3'b101, 40, 4'b1010};
    vecs[10] = '{3'b010,  3, 4'b1011};
    vecs[11] = '{3'b010, 40, 4'b0100};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", int'({led_r, led_g, led_b, busy}), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    wait_edges(4);

    // table vectors
    for (int k = 0; k < 12; k++) begin
      data = vecs[k].data;
      wait_edges(vecs[k].cycles);
      check($sformatf("vec%0d", k), int'({led_r, led_g, led_b, busy}), int'(vecs[k].exp));
    end

    // saturation: hold all targets high long after the ramp completes
    data = 3'b111;
    wait_edges(40);
    for (int k = 0; k < 100; k++) begin
      check("saturate", int'({led_r, led_g, led_b, busy}), 14);
      if (k == 99) check("saturate_level", int'(dut.level_q[0]) + int'(dut.level_q[1]) + int'(dut.level_q[2]), 3 * LMAX);
      @(negedge clk);
    end

    // reversal on blue: clear the target as level 3 is reached so the
    // turn-around step lands on 4
    data = 3'b000;
    wait_edges(40);
    data = 3'b001;
    waited = 0;
    while (m_l[0] != 3 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("rev_reach3_timeout", (waited < 100) ? 1 : 0, 1);
    data = 3'b000;
    last = 3;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      lv = int'(dut.level_q[0]);
      if (lv != last) begin
        seq.push_back(lv);
        last = lv;
      end
    end
    check("rev_seq_len", seq.size(), 5);
    for (int k = 0; k < seq.size() && k < 5; k++)
      check($sformatf("rev_seq%0d", k), seq[k], 4 - k);
    check("rev_busy_done", int'(busy), 0);
    check("rev_led_b_off", int'(led_b), 0);

    // asynchronous reset in the middle of a ramp
    data = 3'b111;
    wait_edges(9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", int'({led_r, led_g, led_b, busy}), 0);
    check("async_rst_levels", int'(dut.level_q[0]) + int'(dut.level_q[1]) + int'(dut.level_q[2]), 0);
    #1 rst = 1'b0;
    wait_edges(1);
    check("post_rst_level", int'(dut.level_q[2]), 0);
    wait_edges(30);
    check("post_rst_full", int'({led_r, led_g, led_b, busy}), 14);

    // concurrency: all three channels ramp in lock-step
    data = 3'b000;
    wait_edges(40);
    data = 3'b111;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("conc_rg", int'(led_r), int'(led_g));
      check("conc_gb", int'(led_g), int'(led_b));
      check("conc_lvl_rg", int'(dut.level_q[2]), int'(dut.level_q[1]));
      check("conc_lvl_gb", int'(dut.level_q[1]), int'(dut.level_q[0]));
    end

    // random target changes, checked every cycle against the model
    for (int k = 0; k < 400; k++) begin
      data = 3'($urandom);
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    data = 3'b000;
    wait_edges(40);
    chk_en = 1'b0;

    // duty at level 3 on the slow instance: reached by rise, then by fall.
    // Strobes land on edges 32, 64, 96, 128, 160 after release.
    for (int w = 0; w < 3; w++) begin
      cnt_rise[w] = 0;
      cnt_fall[w] = 0;
    end
    data_s = 3'b100;
    rst_s = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e >= 100 && e <= 123) cnt_rise[(e - 100) / 8] += int'(led_r_s);
      if (e >= 164 && e <= 187) cnt_fall[(e - 164) / 8] += int'(led_r_s);
      if (e == 129) data_s = 3'b000;
      if (e == 150) check("slow_fall_level4", int'(dut_slow.level_q[2]), 4);
    end
    for (int w = 0; w < 3; w++) begin
      check($sformatf("duty_rise_w%0d", w), cnt_rise[w], 3);
      check($sformatf("duty_fall_w%0d", w), cnt_fall[w], 3);
    end
    check("slow_gb_off", int'({led_g_s, led_b_s}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
